// File: rtl/accumulator_sequencer_if.sv
// rtl/accumulator_sequencer_if.sv - command handshake bundle between host and accumulator_sequencer
interface accumulator_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/accumulator_sequencer.sv
// rtl/accumulator_sequencer.sv - T-state sequencer driving the 8-bit accumulator/ALU control strobes
module accumulator_sequencer (
  input  logic                          clk,
  input  logic                          rst_n,
  accumulator_sequencer_if.slave        cmd,
  output logic [7:0]                    op_data,
  output logic                          ctl_ein,
  output logic                          ctl_nla,
  output logic                          ctl_nlb,
  output logic                          ctl_ea,
  output logic                          ctl_eu,
  output logic                          ctl_sub,
  input  logic                          alu_cf,
  input  logic                          alu_zf,
  output logic                          status_cf,
  output logic                          status_zf,
  output logic                          done,
  output logic                          err,
  output logic [7:0]                    op_count
);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_LDA = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OUT = 3'b100;
  localparam logic [2:0] OP_CLR = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDA,
    S_LDB,
    S_EXEC,
    S_OUT,
    S_CLR,
    S_DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [2:0] op_q;
  logic [7:0] data_q;
  logic       accept;

  assign accept = (state == S_IDLE) && cmd.cmd_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      data_q    <= 8'h00;
      status_cf <= 1'b0;
      status_zf <= 1'b0;
      op_count  <= 8'h00;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q   <= cmd.cmd_op;
        data_q <= cmd.cmd_data;
      end
      // Flags follow the ALU only on the edge where the datapath loads the result.
      if (state == S_EXEC) begin
        status_cf <= alu_cf;
        status_zf <= alu_zf;
      end else if (state == S_CLR) begin
        status_cf <= 1'b0;
        status_zf <= 1'b1;
      end
      if (state == S_DONE) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    cmd.cmd_ready = 1'b0;
    ctl_ein       = 1'b0;
    ctl_nla       = 1'b1;
    ctl_nlb       = 1'b1;
    ctl_ea        = 1'b0;
    ctl_eu        = 1'b0;
    ctl_sub       = 1'b0;
    done          = 1'b0;
    err           = 1'b0;
    op_data       = data_q;

    case (state)
      S_IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            OP_LDA:         state_nx = S_LDA;
            OP_ADD, OP_SUB: state_nx = S_LDB;
            OP_OUT:         state_nx = S_OUT;
            OP_CLR:         state_nx = S_CLR;
            default:        state_nx = S_DONE;
          endcase
        end
      end
      S_LDA: begin
        ctl_ein  = 1'b1;
        ctl_nla  = 1'b0;
        state_nx = S_DONE;
      end
      S_LDB: begin
        ctl_ein  = 1'b1;
        ctl_nlb  = 1'b0;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        ctl_eu   = 1'b1;
        ctl_nla  = 1'b0;
        ctl_sub  = (op_q == OP_SUB);
        state_nx = S_DONE;
      end
      S_OUT: begin
        ctl_ea   = 1'b1;
        state_nx = S_DONE;
      end
      S_CLR: begin
        // Clearing A reuses the input-buffer path with a forced zero operand.
        ctl_ein  = 1'b1;
        ctl_nla  = 1'b0;
        op_data  = 8'h00;
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        err      = (op_q[2:1] == 2'b11);
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// tb/tb_accumulator_sequencer.sv - randomized scoreboard bench for accumulator_sequencer with datapath model
module tb_accumulator_sequencer;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OUT = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  accumulator_sequencer_if cmd_if();

  logic [7:0] op_data, op_count;
  logic ctl_ein, ctl_nla, ctl_nlb, ctl_ea, ctl_eu, ctl_sub;
  logic alu_cf, alu_zf, status_cf, status_zf, done, err;

  accumulator_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cmd_if.slave),
    .op_data   (op_data),
    .ctl_ein   (ctl_ein),
    .ctl_nla   (ctl_nla),
    .ctl_nlb   (ctl_nlb),
    .ctl_ea    (ctl_ea),
    .ctl_eu    (ctl_eu),
    .ctl_sub   (ctl_sub),
    .alu_cf    (alu_cf),
    .alu_zf    (alu_zf),
    .status_cf (status_cf),
    .status_zf (status_zf),
    .done      (done),
    .err       (err),
    .op_count  (op_count)
  );

  // Datapath: registers A/B, adder with carry-out (subtract as A + ~B + 1), shared bus.
  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_b = 8'h00;
  logic [8:0] alu_sum;
  logic [7:0] bus;
  always_comb alu_sum = ctl_sub ? ({1'b0, dp_a} + {1'b0, ~dp_b} + 9'd1) : ({1'b0, dp_a} + {1'b0, dp_b});
  assign alu_cf = alu_sum[8];
  assign alu_zf = (alu_sum[7:0] == 8'h00);
  always_comb bus = ctl_ein ? op_data : (ctl_ea ? dp_a : (ctl_eu ? alu_sum[7:0] : 8'h00));
  always @(posedge clk) begin
    if (!ctl_nla) dp_a <= bus;
    if (!ctl_nlb) dp_b <= bus;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  op;
    logic        err;
    logic        cf;
    logic        zf;
    logic [7:0]  a;
    logic [7:0]  cnt;
    int          done_cyc;
    logic [23:0] act;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  int acc_cyc = -10;
  int end_cyc = -10;

  logic [7:0] ref_a = 8'h00;
  logic       ref_cf = 1'b0;
  logic       ref_zf = 1'b0;
  logic [7:0] ref_cnt = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d: bound expired", name, cyc);
  endtask

  // Reference model: command-level effect on A, flags, count, latency and strobe usage.
  task automatic predict(input logic [2:0] op, input logic [7:0] d);
    exp_t e;
    logic [8:0] r;
    int lat;
    lat = 0;
    e.act = 24'h0;
    case (op)
      OP_LDA: begin
        ref_a = d; lat = 1;
        e.act = {4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
      end
      OP_ADD, OP_SUB: begin
        if (op == OP_ADD) r = {1'b0, ref_a} + {1'b0, d};
        else              r = {1'b0, ref_a} + {1'b0, ~d} + 9'd1;
        ref_a = r[7:0]; ref_cf = r[8]; ref_zf = (r[7:0] == 8'h00); lat = 2;
        e.act = {4'd1, 4'd0, 4'd1, 4'd1, 4'd1, (op == OP_SUB) ? 4'd1 : 4'd0};
      end
      OP_OUT: begin
        lat = 1;
        e.act = {4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
      end
      OP_CLR: begin
        ref_a = 8'h00; ref_cf = 1'b0; ref_zf = 1'b1; lat = 1;
        e.act = {4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
      end
      default: lat = 0;
    endcase
    e.op  = op;
    e.err = (op == 3'd6) || (op == 3'd7);
    e.cf  = ref_cf;
    e.zf  = ref_zf;
    e.a   = ref_a;
    e.cnt = ref_cnt;
    ref_cnt = ref_cnt + 8'd1;
    acc_cyc = cyc + 1;
    end_cyc = acc_cyc + lat;
    e.done_cyc = end_cyc;
    sb.push_back(e);
  endtask

  // Presents a command and holds it until accepted; cmd_valid is left high afterwards.
  task automatic send(input logic [2:0] op, input logic [7:0] d);
    int waited;
    waited = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    forever begin
      @(negedge clk);
      if (cmd_if.cmd_ready) break;
      waited++;
      if (waited > 20) begin
        fail_now("accept_timeout");
        return;
      end
    end
    predict(op, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'($urandom_range(0, 7));
    cmd_if.cmd_data  = 8'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle protocol checks and scoreboard comparison on each done pulse.
  logic [3:0] c_ein, c_ea, c_eu, c_nla, c_nlb, c_sub;
  initial begin
    exp_t e;
    logic exp_ready;
    c_ein = 0; c_ea = 0; c_eu = 0; c_nla = 0; c_nlb = 0; c_sub = 0;
    forever begin
      @(negedge clk);
      if (!chk_en) begin
        c_ein = 0; c_ea = 0; c_eu = 0; c_nla = 0; c_nlb = 0; c_sub = 0;
      end else begin
        exp_ready = !(cyc >= acc_cyc && cyc <= end_cyc);
        check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(exp_ready));
        if (exp_ready)
          check("idle_controls", 32'({ctl_nla, ctl_nlb, ctl_ein, ctl_ea, ctl_eu, ctl_sub}), 32'(6'b110000));
        check("multi_bus_driver", 32'($countones({ctl_ein, ctl_ea, ctl_eu}) > 1), 32'd0);
        c_ein = c_ein + 4'(ctl_ein);
        c_ea  = c_ea  + 4'(ctl_ea);
        c_eu  = c_eu  + 4'(ctl_eu);
        c_nla = c_nla + 4'(!ctl_nla);
        c_nlb = c_nlb + 4'(!ctl_nlb);
        c_sub = c_sub + 4'(ctl_sub);
        if (done) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_done");
          end else begin
            e = sb.pop_front();
            check("done_cycle", 32'(cyc), 32'(e.done_cyc));
            check("err", 32'(err), 32'(e.err));
            check("status_cf", 32'(status_cf), 32'(e.cf));
            check("status_zf", 32'(status_zf), 32'(e.zf));
            check("reg_a", 32'(dp_a), 32'(e.a));
            check("op_count", 32'(op_count), 32'(e.cnt));
            check("strobes", 32'({c_ein, c_ea, c_eu, c_nla, c_nlb, c_sub}), 32'(e.act));
          end
          c_ein = 0; c_ea = 0; c_eu = 0; c_nla = 0; c_nlb = 0; c_sub = 0;
        end else begin
          check("err_without_done", 32'(err), 32'd0);
          if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
            check("done_late", 32'(cyc), 32'(sb[0].done_cyc));
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] rop;
    int waited;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_ADD;
    cmd_if.cmd_data  = 8'h3C;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("rst_controls", 32'({ctl_nla, ctl_nlb, ctl_ein, ctl_ea, ctl_eu, ctl_sub}), 32'(6'b110000));
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_flags", 32'({status_cf, status_zf}), 32'd0);
    check("rst_op_data", 32'(op_data), 32'd0);
    check("rst_done_err", 32'({done, err}), 32'd0);
    cmd_if.cmd_valid = 1'b0;
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_idle", 32'(cmd_if.cmd_ready), 32'd1);

    send(OP_LDA, 8'h05); send(OP_ADD, 8'h03); idle(1);
    send(OP_LDA, 8'h03); send(OP_SUB, 8'h03); idle(2);
    send(OP_LDA, 8'hFF); send(OP_ADD, 8'h01); send(OP_CLR, 8'hA5); idle(1);
    send(OP_LDA, 8'h77); send(OP_OUT, 8'h00); send(3'd7, 8'h12); send(OP_NOP, 8'h34);
    idle(1);

    for (int i = 0; i < 245; i++) begin
      rop = 3'($urandom_range(0, 7));
      send(rop, 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    drain();
    check("op_count_wrap", 32'(op_count), 32'(ref_cnt));
    check("op_count_wrap_zero", 32'(op_count), 32'd0);

    send(OP_LDA, 8'h10);
    send(OP_ADD, 8'h22);
    cmd_if.cmd_valid = 1'b0;
    waited = 0;
    while (!ctl_eu && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    if (!ctl_eu) fail_now("exec_not_reached");
    chk_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("midrst_controls", 32'({ctl_nla, ctl_nlb, ctl_ein, ctl_ea, ctl_eu, ctl_sub}), 32'(6'b110000));
    check("midrst_done", 32'({done, err}), 32'd0);
    check("midrst_flags", 32'({status_cf, status_zf}), 32'd0);
    check("midrst_op_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    sb.delete();
    ref_cnt = 8'h00; ref_cf = 1'b0; ref_zf = 1'b0;
    acc_cyc = -10; end_cyc = -10;
    @(negedge clk);
    check("midrst_no_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    send(OP_LDA, 8'h5A);
    send(OP_SUB, 8'($urandom));
    send(OP_ADD, 8'($urandom));
    idle(1);
    drain();
    check("final_op_count", 32'(op_count), 32'(ref_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
